// File: rtl/ofdm_reorder_pkg.sv
// Shared types and helpers for the FFT output reorder buffer.
// Bank states plus a width-parametrised bit-reversal function.
package ofdm_reorder_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL
    } bank_state_t;

    localparam int MAX_ADDR_W = 16;

    // Reverses the low 'width' bits of idx; upper bits come back zero.
    function automatic logic [MAX_ADDR_W-1:0] bitrev(
        input logic [MAX_ADDR_W-1:0] idx,
        input int                    width
    );
        logic [MAX_ADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_ADDR_W; i++) begin
            if (i < width) begin
                r[width-1-i] = idx[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reorder_bank.sv
// One frame of sample storage: flop array with a synchronous write
// port and a combinational read port.
module reorder_bank #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bit_reverse_reorder_buffer.sv
// Ping-pong frame buffer that re-emits each frame in natural or
// bit-reversed index order, selected by the frame's first sample.
module bit_reverse_reorder_buffer
    import ofdm_reorder_pkg::*;
#(
    parameter  int NUM_POINTS = 8,
    parameter  int DATA_WIDTH = 32,
    localparam int ADDR_WIDTH = $clog2(NUM_POINTS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_reverse,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last,
    output logic [15:0]           frame_count
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_POINTS - 1);

    bank_state_t           r_state [2];
    logic [1:0]            r_mode;
    logic [ADDR_WIDTH-1:0] r_wr_cnt;
    logic [ADDR_WIDTH-1:0] r_rd_cnt;
    logic                  r_wr_bank;
    logic                  r_rd_bank;
    logic [15:0]           r_frame_count;

    logic                  w_in_ready;
    logic                  w_out_valid;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_wr_last;
    logic                  w_rd_last;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [DATA_WIDTH-1:0] w_rdata [2];

    // Ready depends only on registered bank state, never on out_ready.
    assign w_in_ready  = !reset && (r_state[r_wr_bank] != BANK_FULL);
    assign w_out_valid = !reset && (r_state[r_rd_bank] == BANK_FULL);
    assign w_wr        = in_valid && w_in_ready;
    assign w_rd        = w_out_valid && out_ready;
    assign w_wr_last   = w_wr && (r_wr_cnt == LAST_IDX);
    assign w_rd_last   = w_rd && (r_rd_cnt == LAST_IDX);

    assign w_rd_addr = r_mode[r_rd_bank]
        ? ADDR_WIDTH'(bitrev(MAX_ADDR_W'(r_rd_cnt), ADDR_WIDTH))
        : r_rd_cnt;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        reorder_bank #(
            .DEPTH      (NUM_POINTS),
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_bank (
            .clk     (clk),
            .i_we    (w_wr && (r_wr_bank == 1'(b))),
            .i_waddr (r_wr_cnt),
            .i_wdata (in_data),
            .i_raddr (w_rd_addr),
            .o_rdata (w_rdata[b])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state[0] <= BANK_EMPTY;
            r_state[1] <= BANK_EMPTY;
            r_mode     <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                case (r_state[b])
                    BANK_EMPTY: begin
                        if (w_wr && (r_wr_bank == 1'(b))) begin
                            r_state[b] <= BANK_FILLING;
                            r_mode[b]  <= in_reverse;
                        end
                    end
                    BANK_FILLING: begin
                        if (w_wr_last && (r_wr_bank == 1'(b))) begin
                            r_state[b] <= BANK_FULL;
                        end
                    end
                    BANK_FULL: begin
                        if (w_rd_last && (r_rd_bank == 1'(b))) begin
                            r_state[b] <= BANK_EMPTY;
                        end
                    end
                    default: r_state[b] <= BANK_EMPTY;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_cnt      <= '0;
            r_rd_cnt      <= '0;
            r_wr_bank     <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_frame_count <= '0;
        end else begin
            if (w_wr) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
            if (w_wr_last) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (w_rd) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
            if (w_rd_last) begin
                r_rd_bank     <= ~r_rd_bank;
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = w_out_valid;
    assign out_data    = w_out_valid ? w_rdata[r_rd_bank] : '0;
    assign out_index   = w_out_valid ? w_rd_addr : '0;
    assign out_last    = w_out_valid && (r_rd_cnt == LAST_IDX);
    assign frame_count = r_frame_count;

endmodule
